// File: rtl/freq_pkg.sv
// Shared types for the tone-band measurement path.
// Band codes, classifier result constants and the class-to-band map.
package freq_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    BAND_NONE = 2'd0,
    BAND_10   = 2'd1,
    BAND_100  = 2'd2,
    BAND_1000 = 2'd3
  } band_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_EVAL
  } state_e;

  localparam logic [CNT_W-1:0] CLASS_10   = 10'd10;
  localparam logic [CNT_W-1:0] CLASS_100  = 10'd100;
  localparam logic [CNT_W-1:0] CLASS_1000 = 10'd1000;

  function automatic band_e class_to_band(
    input logic [CNT_W-1:0] cls
  );
    band_e b;
    unique case (cls)
      CLASS_10:   b = BAND_10;
      CLASS_100:  b = BAND_100;
      CLASS_1000: b = BAND_1000;
      default:    b = BAND_NONE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/edge_sync_counter.sv
// Two-flop synchroniser, rising-edge detect and saturating edge counter.
// cnt_o already includes an edge counted in the current cycle.
module edge_sync_counter
  import freq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  input  logic             clr_i,
  input  logic             cnt_en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_en_i && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= clr_i ? '0 : cnt_d;
    end
  end

  assign cnt_o = cnt_d;

endmodule

// File: rtl/freq_scan_ctrl.sv
// Gate-window frequency sequencer with confirm filter and band publish.
// FREQ_SCAN_CONFIRM_EN enables the CONFIRM_N filter; otherwise N = 1.
module freq_scan_ctrl
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CONFIRM_N   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_count,
  input  logic [CNT_W-1:0] class_in,
  output logic [1:0]       band_out,
  output logic             band_valid,
  input  logic             band_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int WIN_W = $clog2(GATE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
`ifdef FREQ_SCAN_CONFIRM_EN
  localparam int CONF_N = CONFIRM_N;
`else
  localparam int CONF_N = CONFIRM_N - CONFIRM_N + 1;
`endif
  localparam logic [3:0] CONF_MAX = 4'(CONF_N);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  band_e            last_q, last_d;
  logic [3:0]       conf_q, conf_d;
  band_e            band_q, band_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             clr;
  logic             cnt_en;
  logic             pub;
  logic [CNT_W-1:0] edge_cnt;
  band_e            eval_band;

  edge_sync_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_i    (sig_in),
    .clr_i    (clr),
    .cnt_en_i (cnt_en),
    .cnt_o    (edge_cnt)
  );

  assign eval_band = class_to_band(class_in);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    meas_d  = meas_q;
    last_d  = last_q;
    conf_d  = conf_q;
    band_d  = band_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    clr     = 1'b0;
    cnt_en  = 1'b0;
    pub     = 1'b0;

    if (valid_q && band_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_GATE;
          clr     = 1'b1;
          win_d   = '0;
        end
      end
      ST_GATE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          last_d  = BAND_NONE;
          conf_d  = '0;
        end else begin
          cnt_en = 1'b1;
          if (win_q == WIN_LAST) begin
            meas_d  = edge_cnt;
            state_d = ST_EVAL;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end
      ST_EVAL: begin
        if (eval_band == last_q) begin
          if (conf_q != CONF_MAX) begin
            conf_d = conf_q + 4'd1;
          end
        end else begin
          last_d = eval_band;
          conf_d = 4'd1;
        end
        pub = (conf_d == CONF_MAX) && (eval_band != band_q);
        if (enable) begin
          state_d = ST_GATE;
          clr     = 1'b1;
          win_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A publish overrides a same-cycle transfer and keeps valid high.
    if (pub) begin
      ovr_d   = valid_q && !band_ready;
      band_d  = eval_band;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      meas_q  <= '0;
      last_q  <= BAND_NONE;
      conf_q  <= '0;
      band_q  <= BAND_NONE;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      meas_q  <= meas_d;
      last_q  <= last_d;
      conf_q  <= conf_d;
      band_q  <= band_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign meas_count = meas_q;
  assign band_out   = band_q;
  assign band_valid = valid_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q == ST_GATE) || (state_q == ST_EVAL);

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Randomised bench for freq_scan_ctrl against a window-level model.
// Edges are placed well inside each window so counts are exact.
module tb_freq_scan_ctrl;

  localparam int G  = 2200;
  localparam int CN = 3;
`ifdef FREQ_SCAN_CONFIRM_EN
  localparam int N_EFF = CN;
`else
  localparam int N_EFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sig_in;
  logic [9:0] meas_count;
  logic [9:0] class_in;
  logic [1:0] band_out;
  logic       band_valid;
  logic       band_ready;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  freq_scan_ctrl #(
    .GATE_CYCLES (G),
    .CONFIRM_N   (CN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .meas_count (meas_count),
    .class_in   (class_in),
    .band_out   (band_out),
    .band_valid (band_valid),
    .band_ready (band_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  function automatic logic [9:0] classify(input int c);
    if (c >= 8 && c <= 12) return 10'd10;
    if (c >= 90 && c <= 110) return 10'd100;
    if (c >= 900 && c <= 1010) return 10'd1000;
    return 10'd0;
  endfunction

  always_comb class_in = classify(int'(meas_count));

  function automatic int band_of(input logic [9:0] hz);
    if (hz == 10'd10) return 1;
    if (hz == 10'd100) return 2;
    if (hz == 10'd1000) return 3;
    return 0;
  endfunction

  int vec = 0;
  int errs = 0;
  int rdy_pct = 0;
  int m_last = 0;
  int m_run = 0;
  int m_pub = 0;
  int m_valid = 0;
  int m_ovr = 0;
  int m_meas = 0;
  int ev_pend = 0;
  int wq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic hs_only();
    m_ovr = 0;
    if (m_valid != 0 && band_ready) m_valid = 0;
  endtask

  task automatic do_eval();
    int b;
    b = band_of(classify(m_meas));
    if (b == m_last) m_run++;
    else begin
      m_last = b;
      m_run = 1;
    end
    if (m_run >= N_EFF && b != m_pub) begin
      m_ovr = (m_valid != 0 && !band_ready) ? 1 : 0;
      m_valid = 1;
      m_pub = b;
    end else begin
      hs_only();
    end
  endtask

  task automatic step(input int busy_exp);
    if (ev_pend != 0) begin
      ev_pend = 0;
      do_eval();
    end else begin
      hs_only();
    end
    chk("band_valid", 32'(band_valid), m_valid);
    chk("band_out", 32'(band_out), m_pub);
    chk("overrun", 32'(overrun), m_ovr);
    chk("busy", 32'(busy), busy_exp);
    band_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_meas"}, 32'(meas_count), 0);
    chk({tag, "_band"}, 32'(band_out), 0);
    chk({tag, "_valid"}, 32'(band_valid), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      step(0);
    end
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    m_last = 0;
    m_run = 0;
    m_pub = 0;
    m_valid = 0;
    m_ovr = 0;
    m_meas = 0;
    ev_pend = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic window(input int n, input bit last, input int cut,
                        input bit cut_rst);
    int s;
    s = (n > 0) ? (G - 16) / n : G;
    for (int j = 0; j <= G; j++) begin
      @(negedge clk);
      step(1);
      if (j == G) begin
        m_meas = (n > 1023) ? 1023 : n;
        chk("meas_count", 32'(meas_count), m_meas);
        ev_pend = 1;
        if (last) enable = 1'b0;
      end
      sig_in = (n > 0 && j >= 8 && j <= G - 8 &&
                (j - 8) % s == 0 && (j - 8) / s < n);
      if (j == cut) begin
        sig_in = 1'b0;
        enable = 1'b0;
        if (cut_rst) begin
          reset_mid();
          return;
        end
        @(negedge clk);
        m_last = 0;
        m_run = 0;
        step(0);
        chk("meas_hold", 32'(meas_count), m_meas);
        return;
      end
    end
  endtask

  task automatic run(input int cut_win, input int cut_at, input bit cut_rst);
    enable = 1'b1;
    foreach (wq[i]) begin
      window(wq[i], i == wq.size() - 1,
             (i == cut_win) ? cut_at : -1, cut_rst);
      if (i == cut_win) break;
    end
  endtask

  function automatic int pick();
    case ($urandom_range(4))
      0: return 10;
      1: return 100;
      2: return 1000;
      3: return int'($urandom_range(1090));
      default: return 8 + int'($urandom_range(4));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    band_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    idle(3);

    rdy_pct = 0;
    wq = '{10, 10, 10, 100, 100, 100};
    run(-1, 0, 0);
    idle(20);
    rdy_pct = 100;
    idle(4);

    rdy_pct = 50;
    wq = '{10, 100, 10, 100};
    run(-1, 0, 0);
    idle(10);

    wq = '{10, 10, 10};
    run(2, 500, 0);
    idle(10);
    wq = '{10, 10};
    run(-1, 0, 0);
    idle(10);

    rdy_pct = 0;
    wq = '{1000, 1000, 1000, 1000};
    run(3, 700, 1);
    idle(5);

    rdy_pct = 30;
    wq = '{1050, 1050, 1050};
    run(-1, 0, 0);
    idle(5);

    repeat (3) begin
      int cw;
      wq.delete();
      repeat (3) wq.push_back(pick());
      rdy_pct = int'($urandom_range(100));
      cw = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : -1;
      run(cw, 20 + int'($urandom_range(G - 40)), 1'b0);
      idle(8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
